// File: rtl/simple_threshold_div_49ns_26ns_seq.sv
// Radix-2 restoring unsigned divider, quotient = dividend/divisor, remainder = dividend%divisor.
// Latency: out_valid rises DIVIDEND_WIDTH edges after the accepting edge; one division in flight.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE.
module simple_threshold_div_49ns_26ns_seq #(
  parameter int DIVIDEND_WIDTH = 49,
  parameter int DIVISOR_WIDTH  = 26
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DIVIDEND_WIDTH-1:0] dividend,
  input  logic [DIVISOR_WIDTH-1:0]  divisor,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DIVIDEND_WIDTH-1:0] quotient,
  output logic [DIVISOR_WIDTH-1:0]  remainder,
  output logic                      div_by_zero
);

  localparam int CW = $clog2(DIVIDEND_WIDTH);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                    state, state_nxt;
  logic [DIVIDEND_WIDTH-1:0] shift_q;
  logic [DIVISOR_WIDTH-1:0]  dsr_q;
  logic [DIVISOR_WIDTH-1:0]  rem_q;
  logic [CW-1:0]             cnt_q;
  logic [DIVISOR_WIDTH:0]    rem_shift;
  logic [DIVISOR_WIDTH-1:0]  rem_sub;
  logic [DIVISOR_WIDTH-1:0]  rem_nxt;
  logic                      qbit;
  logic                      last;

  // Between steps the partial remainder is always below the divisor, so only
  // its low DIVISOR_WIDTH bits are stored; the shifted value and compare are one bit wider.
  always_comb begin
    rem_shift = {rem_q, shift_q[DIVIDEND_WIDTH-1]};
    qbit      = (rem_shift >= {1'b0, dsr_q});
    rem_sub   = rem_shift[DIVISOR_WIDTH-1:0] - dsr_q;
    rem_nxt   = qbit ? rem_sub : rem_shift[DIVISOR_WIDTH-1:0];
    last      = (state == BUSY) && (cnt_q == '0);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = BUSY;
      BUSY:    if (last)      state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) state <= IDLE;
    else           state <= state_nxt;
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // Dividend register doubles as the quotient shift register.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      shift_q     <= '0;
      dsr_q       <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      if (state == IDLE && in_valid) begin
        shift_q <= dividend;
        dsr_q   <= divisor;
        rem_q   <= '0;
        cnt_q   <= CW'(DIVIDEND_WIDTH - 1);
      end else if (state == BUSY) begin
        shift_q <= {shift_q[DIVIDEND_WIDTH-2:0], qbit};
        rem_q   <= rem_nxt;
        if (last) begin
          quotient    <= {shift_q[DIVIDEND_WIDTH-2:0], qbit};
          remainder   <= rem_nxt;
          div_by_zero <= (dsr_q == '0);
        end else begin
          cnt_q <= cnt_q - CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_simple_threshold_div_49ns_26ns_seq.sv
// Self-checking bench: directed vector table, multi-cycle corner sequences, random back-to-back vs model.
module tb_simple_threshold_div_49ns_26ns_seq;

  logic        ap_clk;
  logic        ap_rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [48:0] dividend;
  logic [25:0] divisor;
  logic        out_valid;
  logic        out_ready;
  logic [48:0] quotient;
  logic [25:0] remainder;
  logic        div_by_zero;

  int tests = 0;
  int fails = 0;

  simple_threshold_div_49ns_26ns_seq #(.DIVIDEND_WIDTH(49), .DIVISOR_WIDTH(26)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor),
    .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [48:0] a;
    logic [25:0] b;
    logic [48:0] q;
    logic [25:0] r;
    logic        z;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer division; a zero divisor yields all-ones quotient
  // and the dividend truncated to remainder width.
  task automatic ref_div(input logic [48:0] a, input logic [25:0] b,
                         output logic [48:0] q, output logic [25:0] r, output logic z);
    if (b == 26'd0) begin
      q = {49{1'b1}};
      r = a[25:0];
      z = 1'b1;
    end else begin
      q = a / {23'd0, b};
      r = 26'(a % {23'd0, b});
      z = 1'b0;
    end
  endtask

  function automatic logic [48:0] rnd49();
    return 49'({$urandom(), $urandom()});
  endfunction

  task automatic run_op(input logic [48:0] a, input logic [25:0] b,
                        output logic [48:0] q, output logic [25:0] r, output logic z,
                        output int lat);
    int w;
    w = 0;
    while (!in_ready && w < 100) begin
      @(posedge ap_clk); #1; w++;
    end
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    @(posedge ap_clk); #1;
    in_valid = 1'b0;
    dividend = rnd49();
    divisor  = 26'($urandom());
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge ap_clk); #1; lat++;
    end
    q = quotient;
    r = remainder;
    z = div_by_zero;
  endtask

  vec_t        vt[5];
  logic [48:0] q, eq;
  logic [25:0] r, er;
  logic        z, ez;
  int          lat;

  initial begin
    vt[0] = '{a: 49'd1000,            b: 26'd7,         q: 49'd142,              r: 26'd6,     z: 1'b0};
    vt[1] = '{a: 49'h1_FFFF_FFFF_FFFF, b: 26'd1,         q: 49'h1_FFFF_FFFF_FFFF, r: 26'd0,     z: 1'b0};
    vt[2] = '{a: 49'd5,               b: 26'h3FF_FFFF,  q: 49'd0,                r: 26'd5,     z: 1'b0};
    vt[3] = '{a: 49'd12345,           b: 26'd0,         q: 49'h1_FFFF_FFFF_FFFF, r: 26'd12345, z: 1'b1};
    vt[4] = '{a: 49'd100,             b: 26'd10,        q: 49'd10,               r: 26'd0,     z: 1'b0};

    ap_rst_n  = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    dividend  = '0;
    divisor   = '0;
    #12;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_quotient", 64'(quotient), 64'd0);
    chk("rst_remainder", 64'(remainder), 64'd0);
    chk("rst_dbz", 64'(div_by_zero), 64'd0);
    ap_rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge ap_clk); #1;

    for (int i = 0; i < 5; i++) begin
      run_op(vt[i].a, vt[i].b, q, r, z, lat);
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd49);
      chk($sformatf("vec%0d_quotient", i), 64'(q), 64'(vt[i].q));
      chk($sformatf("vec%0d_remainder", i), 64'(r), 64'(vt[i].r));
      chk($sformatf("vec%0d_dbz", i), 64'(z), 64'(vt[i].z));
      @(posedge ap_clk); #1;
      chk($sformatf("vec%0d_handoff_valid", i), 64'(out_valid), 64'd0);
      chk($sformatf("vec%0d_in_ready_after", i), 64'(in_ready), 64'd1);
    end

    // Backpressure: result must hold while out_ready is low, new inputs ignored.
    out_ready = 1'b0;
    ref_div(49'h1234_5678_9ABC, 26'h00F_FFFF, eq, er, ez);
    run_op(49'h1234_5678_9ABC, 26'h00F_FFFF, q, r, z, lat);
    chk("bp_latency", 64'(lat), 64'd49);
    chk("bp_quotient", 64'(q), 64'(eq));
    chk("bp_remainder", 64'(r), 64'(er));
    for (int c = 0; c < 10; c++) begin
      in_valid = c[0];
      dividend = rnd49();
      divisor  = 26'($urandom());
      @(posedge ap_clk); #1;
      chk("bp_hold_valid", 64'(out_valid), 64'd1);
      chk("bp_hold_in_ready", 64'(in_ready), 64'd0);
      chk("bp_hold_quotient", 64'(quotient), 64'(eq));
      chk("bp_hold_remainder", 64'(remainder), 64'(er));
      chk("bp_hold_dbz", 64'(div_by_zero), 64'(ez));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge ap_clk); #1;
    chk("bp_release_valid", 64'(out_valid), 64'd0);
    chk("bp_release_in_ready", 64'(in_ready), 64'd1);
    chk("bp_release_quotient_kept", 64'(quotient), 64'(eq));

    // Reset in the middle of a division.
    dividend = 49'd1000;
    divisor  = 26'd7;
    in_valid = 1'b1;
    @(posedge ap_clk); #1;
    in_valid = 1'b0;
    repeat (20) @(posedge ap_clk);
    #1;
    chk("midrst_pre_valid", 64'(out_valid), 64'd0);
    ap_rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_quotient", 64'(quotient), 64'd0);
    chk("midrst_remainder", 64'(remainder), 64'd0);
    chk("midrst_dbz", 64'(div_by_zero), 64'd0);
    #3;
    ap_rst_n = 1'b1;
    run_op(49'd81, 26'd9, q, r, z, lat);
    chk("postrst_latency", 64'(lat), 64'd49);
    chk("postrst_quotient", 64'(q), 64'd9);
    chk("postrst_remainder", 64'(r), 64'd0);
    @(posedge ap_clk); #1;

    // Random back-to-back with in_valid held high.
    begin
      logic [48:0] qa[$];
      logic [25:0] qb[$];
      int          n_acc, n_done, cyc, prev_acc;
      logic        rdy_now, vld_now;
      logic [48:0] q_now;
      logic [25:0] r_now;
      logic        z_now;
      logic [48:0] ta;
      logic [25:0] tb_b;
      n_acc    = 0;
      n_done   = 0;
      cyc      = 0;
      prev_acc = -1;
      dividend = rnd49();
      divisor  = 26'($urandom_range(1, 1000));
      in_valid = 1'b1;
      while (n_done < 200 && cyc < 12000) begin
        rdy_now = in_ready && in_valid;
        vld_now = out_valid;
        q_now   = quotient;
        r_now   = remainder;
        z_now   = div_by_zero;
        @(posedge ap_clk); #1;
        cyc++;
        if (rdy_now) begin
          qa.push_back(dividend);
          qb.push_back(divisor);
          if (prev_acc >= 0) chk("b2b_interval", 64'(cyc - prev_acc), 64'd51);
          prev_acc = cyc;
          n_acc++;
          case ($urandom_range(0, 3))
            0:       divisor = 26'd0;
            1:       divisor = 26'($urandom_range(1, 255));
            2:       divisor = 26'h3FF_FFFF;
            default: divisor = 26'($urandom());
          endcase
          dividend = ($urandom_range(0, 4) == 0) ? 49'($urandom_range(0, 1000)) : rnd49();
          if (n_acc == 200) in_valid = 1'b0;
        end
        if (vld_now) begin
          if (qa.size() == 0) begin
            chk("b2b_unexpected_result", 64'd1, 64'd0);
          end else begin
            ta   = qa.pop_front();
            tb_b = qb.pop_front();
            ref_div(ta, tb_b, eq, er, ez);
            chk("b2b_quotient", 64'(q_now), 64'(eq));
            chk("b2b_remainder", 64'(r_now), 64'(er));
            chk("b2b_dbz", 64'(z_now), 64'(ez));
          end
          n_done++;
        end
      end
      chk("b2b_completed", 64'(n_done), 64'd200);
      in_valid = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
